// File: rtl/menu_pkg.sv
// Shared types and helpers for the menu controller.
package menu_pkg;

   typedef enum logic [1:0] {
      NAV,
      CONFIRM,
      DONE
   } state_t;

   typedef struct packed {
      logic [2:0] r;
      logic [2:0] g;
      logic [1:0] b;
   } rgb8_t;

   localparam int FRAME_TICK_H = 0;

   function automatic int idx_w(input int n);
      return $clog2(n);
   endfunction

endpackage

// File: rtl/btn_edge.sv
// Two-flop synchroniser for a raw push-button plus a rising-edge pulse.
module btn_edge (
   input  logic clock,
   input  logic reset,
   input  logic btn,
   output logic rise
);

   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;
   logic prev_q, prev_d;

   always_comb begin
      sync1_d = btn;
      sync2_d = sync1_q;
      prev_d  = sync2_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
      end
   end

   assign rise = sync2_q & ~prev_q;

endmodule

// File: rtl/menu_ctrl.sv
// Frame-synchronous menu controller: cursor FSM, sprite placement, pixel merge.
// Define MENU_BLINK_EN to blink the selected sprite every 8 frames in CONFIRM.
module menu_ctrl
   import menu_pkg::*;
#(
   parameter int N_BTN       = 4,
   parameter int BASE_X      = 280,
   parameter int BASE_Y      = 150,
   parameter int STEP_Y      = 40,
   parameter int V_ACTIVE    = 480,
   parameter int HOLD_FRAMES = 30
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [9:0]                 hcount,
   input  logic [9:0]                 vcount,
   input  logic                       btn_up,
   input  logic                       btn_down,
   input  logic                       btn_sel,
   input  logic [N_BTN-1:0]           spr_data,
   input  logic [8*N_BTN-1:0]         spr_rgb,
   output logic [N_BTN-1:0]           spr_en,
   output logic [10*N_BTN-1:0]        spr_posx,
   output logic [10*N_BTN-1:0]        spr_posy,
   output logic [2:0]                 red,
   output logic [2:0]                 green,
   output logic [1:0]                 blue,
   output logic                       data,
   output logic [idx_w(N_BTN)-1:0]    cursor,
   output logic [idx_w(N_BTN)-1:0]    choice,
   output logic                       choice_valid
);

   localparam int IW = idx_w(N_BTN);
   localparam int CW = $clog2(HOLD_FRAMES + 1);
   localparam logic [N_BTN-1:0] EN_ONE = 1;
   localparam logic [N_BTN-1:0] EN_ALL = '1;

   if (BASE_Y + (N_BTN - 1) * STEP_Y >= 1024 ||
       N_BTN < 2 || N_BTN > 8 || HOLD_FRAMES < 1) begin : g_bad
      $error("menu_ctrl: parameter out of range");
   end

   for (genvar i = 0; i < N_BTN; i++) begin : g_pos
      assign spr_posx[10*i +: 10] = 10'(BASE_X);
      assign spr_posy[10*i +: 10] = 10'(BASE_Y + i * STEP_Y);
   end

   logic up_rise, down_rise, sel_rise;

   btn_edge u_up   (.clock(clock), .reset(reset), .btn(btn_up),   .rise(up_rise));
   btn_edge u_down (.clock(clock), .reset(reset), .btn(btn_down), .rise(down_rise));
   btn_edge u_sel  (.clock(clock), .reset(reset), .btn(btn_sel),  .rise(sel_rise));

   logic frame_tick;
   assign frame_tick = (hcount == 10'(FRAME_TICK_H)) &&
                       (vcount == 10'(V_ACTIVE));

   state_t          state_q, state_d;
   logic [IW-1:0]   cursor_q, cursor_d;
   logic [IW-1:0]   choice_q, choice_d;
   logic            cv_q, cv_d;
   logic [N_BTN-1:0] en_q, en_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            pu_q, pu_d, pd_q, pd_d, ps_q, ps_d;
   rgb8_t           rgb_q, rgb_d;
   logic            data_q, data_d;
`ifdef MENU_BLINK_EN
   logic [2:0]      blink_q, blink_d;
`endif

   logic            up_f, down_f, sel_f;
   logic            win_hit;
   logic [IW-1:0]   win_idx;
   rgb8_t           win_rgb;

   always_comb begin
      state_d  = state_q;
      cursor_d = cursor_q;
      choice_d = choice_q;
      cv_d     = 1'b0;
      en_d     = en_q;
      cnt_d    = cnt_q;
`ifdef MENU_BLINK_EN
      blink_d  = blink_q;
`endif
      up_f     = pu_q | up_rise;
      down_f   = pd_q | down_rise;
      sel_f    = ps_q | sel_rise;
      pu_d     = up_f;
      pd_d     = down_f;
      ps_d     = sel_f;

      unique case (state_q)
         NAV: begin
            if (frame_tick) begin
               pu_d = 1'b0;
               pd_d = 1'b0;
               ps_d = 1'b0;
               if (sel_f) begin
                  state_d = CONFIRM;
                  cnt_d   = CW'(HOLD_FRAMES - 1);
                  en_d    = EN_ONE << cursor_q;
`ifdef MENU_BLINK_EN
                  blink_d = 3'd0;
`endif
               end else if (up_f && !down_f) begin
                  if (cursor_q == '0) cursor_d = IW'(N_BTN - 1);
                  else                cursor_d = cursor_q - IW'(1);
               end else if (down_f && !up_f) begin
                  if (cursor_q == IW'(N_BTN - 1)) cursor_d = '0;
                  else                            cursor_d = cursor_q + IW'(1);
               end
            end
         end
         CONFIRM: begin
            // Presses are dropped for the whole hold period.
            pu_d = 1'b0;
            pd_d = 1'b0;
            ps_d = 1'b0;
            if (frame_tick) begin
               if (cnt_q == '0) begin
                  state_d  = DONE;
                  choice_d = cursor_q;
                  cv_d     = 1'b1;
                  en_d     = EN_ALL;
               end else begin
                  cnt_d = cnt_q - CW'(1);
`ifdef MENU_BLINK_EN
                  blink_d = blink_q + 3'd1;
                  if (blink_q == 3'd7) en_d = en_q ^ (EN_ONE << cursor_q);
`endif
               end
            end
         end
         DONE: begin
            state_d = NAV;
         end
         default: state_d = NAV;
      endcase
   end

   always_comb begin
      win_hit = 1'b0;
      win_idx = '0;
      win_rgb = '0;
      for (int i = N_BTN - 1; i >= 0; i--) begin
         if (spr_data[i]) begin
            win_hit = 1'b1;
            win_idx = IW'(i);
            win_rgb = spr_rgb[8*i +: 8];
         end
      end
      data_d = win_hit;
      rgb_d  = rgb_q;
      if (win_hit) begin
         if (win_idx == cursor_q && state_q == NAV) rgb_d = ~win_rgb;
         else                                       rgb_d = win_rgb;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= NAV;
         cursor_q <= '0;
         choice_q <= '0;
         cv_q     <= 1'b0;
         en_q     <= EN_ALL;
         cnt_q    <= '0;
         pu_q     <= 1'b0;
         pd_q     <= 1'b0;
         ps_q     <= 1'b0;
         rgb_q    <= '0;
         data_q   <= 1'b0;
`ifdef MENU_BLINK_EN
         blink_q  <= 3'd0;
`endif
      end else begin
         state_q  <= state_d;
         cursor_q <= cursor_d;
         choice_q <= choice_d;
         cv_q     <= cv_d;
         en_q     <= en_d;
         cnt_q    <= cnt_d;
         pu_q     <= pu_d;
         pd_q     <= pd_d;
         ps_q     <= ps_d;
         rgb_q    <= rgb_d;
         data_q   <= data_d;
`ifdef MENU_BLINK_EN
         blink_q  <= blink_d;
`endif
      end
   end

   assign spr_en       = en_q;
   assign red          = rgb_q.r;
   assign green        = rgb_q.g;
   assign blue         = rgb_q.b;
   assign data         = data_q;
   assign cursor       = cursor_q;
   assign choice       = choice_q;
   assign choice_valid = cv_q;

endmodule

// File: tb/tb_menu_ctrl.sv
// Directed + randomized bench for menu_ctrl against a frame-level model.
module tb_menu_ctrl;

   localparam int N = 4;
   localparam int HOLD = 30;

   logic         clock = 1'b0;
   logic         reset;
   logic [9:0]   hcount, vcount;
   logic         btn_up, btn_down, btn_sel;
   logic [N-1:0] spr_data;
   logic [8*N-1:0] spr_rgb;
   logic [N-1:0] spr_en;
   logic [10*N-1:0] spr_posx, spr_posy;
   logic [2:0]   red, green;
   logic [1:0]   blue;
   logic         data;
   logic [1:0]   cursor, choice;
   logic         choice_valid;

   int checks = 0;
   int errors = 0;

   int m_cur;
   logic [7:0] m_rgb;

   menu_ctrl dut (
      .clock(clock), .reset(reset),
      .hcount(hcount), .vcount(vcount),
      .btn_up(btn_up), .btn_down(btn_down), .btn_sel(btn_sel),
      .spr_data(spr_data), .spr_rgb(spr_rgb),
      .spr_en(spr_en), .spr_posx(spr_posx), .spr_posy(spr_posy),
      .red(red), .green(green), .blue(blue), .data(data),
      .cursor(cursor), .choice(choice), .choice_valid(choice_valid)
   );

   always #5 clock = ~clock;

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic press(input int which);
      case (which)
         0: btn_up = 1'b1;
         1: btn_down = 1'b1;
         default: btn_sel = 1'b1;
      endcase
      step(4);
      btn_up = 1'b0;
      btn_down = 1'b0;
      btn_sel = 1'b0;
      step(4);
   endtask

   task automatic tick();
      hcount = 10'd0;
      vcount = 10'd480;
      step(1);
      hcount = 10'd10;
      vcount = 10'd100;
   endtask

   task automatic nav(input bit up, input bit down, input string tag);
      if (up) press(0);
      if (down) press(1);
      chk({tag, "_pre"}, cursor, m_cur);
      tick();
      if (up && !down) m_cur = (m_cur + N - 1) % N;
      if (down && !up) m_cur = (m_cur + 1) % N;
      chk(tag, cursor, m_cur);
   endtask

   task automatic pix(input logic [N-1:0] d, input logic [8*N-1:0] c,
                      input string tag);
      int w;
      logic [7:0] s;
      spr_data = d;
      spr_rgb = c;
      w = -1;
      for (int i = 0; i < N; i++)
         if (w < 0 && d[i]) w = i;
      if (w >= 0) begin
         s = c[8*w +: 8];
         m_rgb = (w == m_cur) ? ~s : s;
      end
      step(1);
      chk({tag, "_data"}, data, (w >= 0));
      chk({tag, "_rgb"}, {red, green, blue}, m_rgb);
   endtask

   initial begin
      logic [N-1:0] exp_en;
      int op;
      reset = 1'b1;
      hcount = 10'd10;
      vcount = 10'd100;
      btn_up = 1'b0;
      btn_down = 1'b0;
      btn_sel = 1'b0;
      spr_data = '0;
      spr_rgb = '0;
      m_cur = 0;
      m_rgb = 8'h00;
      step(2);
      chk("rst_cursor", cursor, 0);
      chk("rst_data", data, 0);
      chk("rst_en", spr_en, 4'b1111);
      chk("rst_cv", choice_valid, 0);
      chk("rst_choice", choice, 0);
      chk("posx3", spr_posx[30 +: 10], 280);
      chk("posy3", spr_posy[30 +: 10], 150 + 3 * 40);
      reset = 1'b0;
      step(2);

      nav(0, 1, "down1");
      nav(0, 1, "down2");
      nav(0, 1, "down3");
      nav(0, 1, "down4_wrap");
      chk("wrap_zero", cursor, 0);
      nav(1, 0, "up_wrap");
      chk("up_wrap3", cursor, 3);
      nav(1, 1, "both_cancel");
      nav(0, 0, "idle");

      for (int k = 0; k < 12; k++) begin
         op = $urandom_range(0, 3);
         nav(op == 0 || op == 2, op == 1 || op == 2, "rnd_nav");
      end

      for (int k = 0; k < N && m_cur != 2; k++)
         nav(0, 1, "to2");
      chk("at2", cursor, 2);

      press(2);
      tick();
      exp_en = 4'b0100;
      chk("cf_en0", spr_en, exp_en);
      for (int j = 1; j < HOLD; j++) begin
         if (j == 5) press(0);
         if (j == 9) press(1);
         tick();
`ifdef MENU_BLINK_EN
         exp_en = ((j / 8) % 2 == 0) ? 4'b0100 : 4'b0000;
`endif
         chk("cf_en", spr_en, exp_en);
         chk("cf_cv", choice_valid, 0);
         chk("cf_cur", cursor, 2);
      end
      tick();
      chk("done_cv", choice_valid, 1);
      chk("done_choice", choice, 2);
      chk("done_en", spr_en, 4'b1111);
      step(1);
      chk("cv_pulse", choice_valid, 0);
      nav(0, 0, "post_cf");

      for (int k = 0; k < N && m_cur != 1; k++)
         nav(0, 1, "to1");
      pix(4'b0110, {8'h00, 8'h1C, 8'hE0, 8'h00}, "pix_inv");
      chk("pix_1f", {red, green, blue}, 8'h1F);
      nav(1, 0, "to0");
      pix(4'b0110, {8'h00, 8'h1C, 8'hE0, 8'h00}, "pix_pl");
      chk("pix_e0", {red, green, blue}, 8'hE0);
      pix(4'b0000, {8'hFF, 8'hFF, 8'hFF, 8'hFF}, "pix_hold");
      for (int k = 0; k < 16; k++)
         pix(N'($urandom), {$urandom}, "pix_rnd");
      spr_data = '0;

      press(2);
      tick();
      tick();
      tick();
      reset = 1'b1;
      step(2);
      reset = 1'b0;
      m_cur = 0;
      chk("ab_cursor", cursor, 0);
      chk("ab_en", spr_en, 4'b1111);
      chk("ab_data", data, 0);
      chk("ab_choice", choice, 0);
      for (int j = 0; j < HOLD + 2; j++) begin
         tick();
         chk("ab_cv", choice_valid, 0);
         chk("ab_en_nav", spr_en, 4'b1111);
      end
      nav(0, 1, "ab_nav");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
